// File: rtl/pp_ring_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pp_ring_ram_pkg
// Brief    : Shared constants and sizing helpers for the packet ring RAM.
// Revision : 1.0 - initial release
// ============================================================================
package pp_ring_ram_pkg;

    // Width and saturation value of the optional refused-commit counter.
    localparam int         FAIL_CNT_W   = 8;
    localparam logic [7:0] FAIL_CNT_MAX = 8'hFF;

    // Number of frame buffers in the ring.
    function automatic int ring_nbuf(input int n_width);
        return 1 << n_width;
    endfunction

    // Total word count of the backing RAM (all buffers).
    function automatic int ring_depth(input int n_width, input int a_width);
        return (1 << n_width) << a_width;
    endfunction

endpackage : pp_ring_ram_pkg
`default_nettype wire

// File: rtl/pp_ring_mem.sv
`default_nettype none
// ============================================================================
// Module   : pp_ring_mem
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port, no reset so it maps onto block RAM. A read of a word
//            that is written on the same edge returns the old word.
// Revision : 1.0 - initial release
// ============================================================================
module pp_ring_mem
    import pp_ring_ram_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port share one clock edge (read-old).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule : pp_ring_mem
`default_nettype wire

// File: rtl/pp_ring_ram.sv
`default_nettype none
// ============================================================================
// Module   : pp_ring_ram
// Brief    : Ring of 2**N_WIDTH frame buffers. The writer fills the current
//            write buffer and commits it with flags and length; the reader
//            drains committed buffers in order. One buffer is always kept
//            free for the writer, so at most 2**N_WIDTH-1 frames are pending.
//            Optional macro PP_RING_FAIL_CNT_EN adds a saturating counter of
//            refused commits (fail_cnt_o), cleared only by reset_n.
// Revision : 1.0 - initial release
// ============================================================================
module pp_ring_ram
    import pp_ring_ram_pkg::*;
#(
    parameter int DW      = 8,
    parameter int A_WIDTH = 8,
    parameter int N_WIDTH = 2,
    parameter int F_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DW-1:0]         wr_data_i,
    input  logic [A_WIDTH-1:0]    wr_addr_i,
    input  logic                  wr_en_i,
    input  logic                  commit_i,
    input  logic [F_WIDTH-1:0]    wr_flags_i,
    input  logic [A_WIDTH:0]      wr_len_i,
    input  logic                  wr_abort_i,
    output logic                  commit_fail_o,
    input  logic [A_WIDTH-1:0]    rd_addr_i,
    output logic [DW-1:0]         rd_data_o,
    output logic [F_WIDTH-1:0]    rd_flags_o,
    output logic [A_WIDTH:0]      rd_len_o,
    input  logic                  rd_done_i,
    input  logic                  rd_done_all_i,
    output logic                  unread_o,
    output logic [N_WIDTH:0]      pending_o
`ifdef PP_RING_FAIL_CNT_EN
    ,
    output logic [FAIL_CNT_W-1:0] fail_cnt_o
`endif
);

    localparam int NBUF  = ring_nbuf(N_WIDTH);
    localparam int LEN_W = A_WIDTH + 1;
    localparam int DEPTH = ring_depth(N_WIDTH, A_WIDTH);

    logic [N_WIDTH-1:0] wr_sel_q,  wr_sel_d;
    logic [N_WIDTH-1:0] rd_sel_q,  rd_sel_d;
    logic [NBUF-1:0]    dirty_q,   dirty_d;
    logic [N_WIDTH:0]   pending_q, pending_d;
    logic               commit_fail_q, commit_fail_d;
    logic [F_WIDTH-1:0] flags_q [NBUF];
    logic [LEN_W-1:0]   len_q   [NBUF];
    logic [F_WIDTH-1:0] rd_flags_q;
    logic [LEN_W-1:0]   rd_len_q;

    logic [N_WIDTH-1:0] wr_next;
    logic               commit_req;
    logic               commit_ok;
    logic               commit_refuse;
    logic               release_ok;

    // Commit/release decisions use the pre-cycle dirty state; flush wins over all.
    always_comb begin
        wr_next       = wr_sel_q + N_WIDTH'(1);
        commit_req    = commit_i & ~wr_abort_i & ~rd_done_all_i;
        commit_ok     = commit_req & ~dirty_q[wr_next];
        commit_refuse = commit_req &  dirty_q[wr_next];
        release_ok    = rd_done_i & dirty_q[rd_sel_q] & ~rd_done_all_i;

        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        dirty_d       = dirty_q;
        pending_d     = pending_q;
        commit_fail_d = commit_refuse;

        if (rd_done_all_i) begin
            wr_sel_d  = '0;
            rd_sel_d  = '0;
            dirty_d   = '0;
            pending_d = '0;
        end else begin
            if (release_ok) begin
                dirty_d[rd_sel_q] = 1'b0;
                rd_sel_d          = rd_sel_q + N_WIDTH'(1);
            end
            if (commit_ok) begin
                dirty_d[wr_sel_q] = 1'b1;
                wr_sel_d          = wr_next;
            end
            case ({commit_ok, release_ok})
                2'b10:   pending_d = pending_q + (N_WIDTH+1)'(1);
                2'b01:   pending_d = pending_q - (N_WIDTH+1)'(1);
                default: pending_d = pending_q;
            endcase
        end
    end

    // Ring control state and per-buffer descriptors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            dirty_q       <= '0;
            pending_q     <= '0;
            commit_fail_q <= 1'b0;
            rd_flags_q    <= '0;
            rd_len_q      <= '0;
            for (int i = 0; i < NBUF; i++) begin
                flags_q[i] <= '0;
                len_q[i]   <= '0;
            end
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            dirty_q       <= dirty_d;
            pending_q     <= pending_d;
            commit_fail_q <= commit_fail_d;
            rd_flags_q    <= dirty_q[rd_sel_q] ? flags_q[rd_sel_q] : '0;
            rd_len_q      <= dirty_q[rd_sel_q] ? len_q[rd_sel_q]   : '0;
            if (commit_ok) begin
                flags_q[wr_sel_q] <= wr_flags_i;
                len_q[wr_sel_q]   <= wr_len_i;
            end
        end
    end

`ifdef PP_RING_FAIL_CNT_EN
    logic [FAIL_CNT_W-1:0] fail_cnt_q;

    // Saturating count of refused commits; flush does not clear it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_cnt_q <= '0;
        end else if (commit_refuse && (fail_cnt_q != FAIL_CNT_MAX)) begin
            fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
        end
    end

    assign fail_cnt_o = fail_cnt_q;
`endif

    pp_ring_mem #(
        .DW    (DW),
        .AW    (N_WIDTH + A_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en_i),
        .waddr_i ({wr_sel_q, wr_addr_i}),
        .wdata_i (wr_data_i),
        .raddr_i ({rd_sel_q, rd_addr_i}),
        .rdata_o (rd_data_o)
    );

    assign commit_fail_o = commit_fail_q;
    assign rd_flags_o    = rd_flags_q;
    assign rd_len_o      = rd_len_q;
    assign pending_o     = pending_q;
    assign unread_o      = (pending_q != '0);

endmodule : pp_ring_ram
`default_nettype wire

// File: tb/tb_pp_ring_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_ring_ram
// Brief    : Directed bench for pp_ring_ram. Stimulus queues expected values
//            tagged with the cycle they must appear in; an independent
//            monitor compares them on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_ring_ram;

    localparam int DW = 8, AW = 8, NW = 2, FW = 8;

    localparam int F_PEND = 0, F_UNREAD = 1, F_FLAGS = 2, F_LEN = 3,
                   F_DATA = 4, F_FAIL = 5, F_FCNT = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en, commit, wr_abort, rd_done, rd_done_all;
    logic [FW-1:0] wr_flags;
    logic [AW:0]   wr_len;
    logic          commit_fail;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [FW-1:0] rd_flags;
    logic [AW:0]   rd_len;
    logic          unread;
    logic [NW:0]   pending;
    logic [7:0]    fail_cnt;

    pp_ring_ram #(.DW(DW), .A_WIDTH(AW), .N_WIDTH(NW), .F_WIDTH(FW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_data_i     (wr_data),
        .wr_addr_i     (wr_addr),
        .wr_en_i       (wr_en),
        .commit_i      (commit),
        .wr_flags_i    (wr_flags),
        .wr_len_i      (wr_len),
        .wr_abort_i    (wr_abort),
        .commit_fail_o (commit_fail),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_flags_o    (rd_flags),
        .rd_len_o      (rd_len),
        .rd_done_i     (rd_done),
        .rd_done_all_i (rd_done_all),
        .unread_o      (unread),
        .pending_o     (pending)
`ifdef PP_RING_FAIL_CNT_EN
        ,
        .fail_cnt_o    (fail_cnt)
`endif
    );

`ifndef PP_RING_FAIL_CNT_EN
    assign fail_cnt = 8'd0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic expect_at(input int d, input int f, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + d;
        e.fld  = f;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_PEND:   return 32'(pending);
            F_UNREAD: return 32'(unread);
            F_FLAGS:  return 32'(rd_flags);
            F_LEN:    return 32'(rd_len);
            F_DATA:   return 32'(rd_data);
            F_FAIL:   return 32'(commit_fail);
            default:  return 32'(fail_cnt);
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin : mon
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = actual(sb[i].fld);
                n_vec++;
                if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        commit      = 1'b0;
        wr_abort    = 1'b0;
        rd_done     = 1'b0;
        rd_done_all = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic set_commit(input logic [FW-1:0] f, input logic [AW:0] l);
        commit   = 1'b1;
        wr_flags = f;
        wr_len   = l;
    endtask

    initial begin
        reset_n = 1'b0; wr_data = '0; wr_addr = '0; wr_en = 1'b0; commit = 1'b0;
        wr_flags = '0; wr_len = '0; wr_abort = 1'b0; rd_addr = '0;
        rd_done = 1'b0; rd_done_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        expect_at(0, F_PEND, 0, "rst_pending");
        expect_at(0, F_UNREAD, 0, "rst_unread");
        expect_at(0, F_FLAGS, 0, "rst_flags");
        expect_at(0, F_LEN, 0, "rst_len");
        expect_at(0, F_FAIL, 0, "rst_commit_fail");
`ifdef PP_RING_FAIL_CNT_EN
        expect_at(0, F_FCNT, 0, "rst_fail_cnt");
`endif
        step();

        // Single frame into buffer 0
        write_word(0, 8'hA5); step();
        set_commit(8'h3C, 1);
        expect_at(1, F_PEND, 1, "single_pending");
        expect_at(1, F_UNREAD, 1, "single_unread");
        expect_at(1, F_FAIL, 0, "single_no_fail");
        expect_at(1, F_DATA, 8'hA5, "single_data");
        expect_at(2, F_FLAGS, 8'h3C, "single_flags");
        expect_at(2, F_LEN, 1, "single_len");
        step();

        // Fill ring: buffers 1 and 2, then a refused 4th commit
        write_word(0, 8'h11); step();
        set_commit(8'h41, 2); step();
        write_word(0, 8'h22); step();
        set_commit(8'h42, 3);
        expect_at(1, F_PEND, 3, "fill_pending3");
        step();
        set_commit(8'h99, 7);
        expect_at(1, F_FAIL, 1, "fill_commit_fail");
        expect_at(1, F_PEND, 3, "fill_pending_hold");
        expect_at(2, F_FAIL, 0, "fill_fail_pulse_end");
`ifdef PP_RING_FAIL_CNT_EN
        expect_at(1, F_FCNT, 1, "fill_fail_cnt");
`endif
        step(); step();

        // Drain buffers 0 and 1
        rd_done = 1'b1;
        expect_at(1, F_PEND, 2, "drain0_pending");
        expect_at(2, F_FLAGS, 8'h41, "drain0_next_flags");
        expect_at(2, F_LEN, 2, "drain0_next_len");
        expect_at(2, F_DATA, 8'h11, "drain0_next_data");
        step(); step();
        rd_done = 1'b1;
        expect_at(1, F_PEND, 1, "drain1_pending");
        expect_at(2, F_FLAGS, 8'h42, "drain1_next_flags");
        expect_at(2, F_DATA, 8'h22, "drain1_next_data");
        step(); step();

        // Simultaneous commit (buffer 3) and release (buffer 2) with pending=1
        write_word(0, 8'h33); step();
        set_commit(8'h43, 4);
        rd_done = 1'b1;
        expect_at(1, F_PEND, 1, "simul_pending");
        expect_at(1, F_FAIL, 0, "simul_no_fail");
        expect_at(2, F_FLAGS, 8'h43, "simul_flags");
        expect_at(2, F_LEN, 4, "simul_len");
        expect_at(2, F_DATA, 8'h33, "simul_data");
        step(); step();
        rd_done = 1'b1;
        expect_at(1, F_PEND, 0, "empty_pending");
        expect_at(1, F_UNREAD, 0, "empty_unread");
        expect_at(2, F_FLAGS, 0, "empty_flags");
        expect_at(2, F_LEN, 0, "empty_len");
        step(); step();

        // Wrap: ten frames through the ring starting at buffer 0
        for (int i = 0; i < 10; i++) begin
            write_word(5, 8'(8'h80 + i)); step();
            set_commit(8'(8'h10 + i), 9'(i + 1));
            rd_addr = 5;
            expect_at(1, F_PEND, 1, "wrap_pending");
            expect_at(1, F_DATA, 32'(8'h80 + i), "wrap_data");
            expect_at(2, F_FLAGS, 32'(8'h10 + i), "wrap_flags");
            expect_at(2, F_LEN, 32'(i + 1), "wrap_len");
            step();
            rd_done = 1'b1;
            expect_at(1, F_PEND, 0, "wrap_release");
            step(); step();
        end
        rd_addr = 0;

        // Release on an empty ring is ignored
        rd_done = 1'b1;
        expect_at(1, F_PEND, 0, "empty_release_pending");
        expect_at(1, F_UNREAD, 0, "empty_release_unread");
        step();

        // Abort beats a same-cycle commit
        set_commit(8'hEE, 2);
        wr_abort = 1'b1;
        expect_at(1, F_PEND, 0, "abort_pending");
        expect_at(1, F_FAIL, 0, "abort_no_fail");
        expect_at(2, F_FLAGS, 0, "abort_flags");
        step(); step();

        // Flush with pending=2 and a same-cycle commit
        set_commit(8'h51, 1); step();
        set_commit(8'h52, 1);
        expect_at(1, F_PEND, 2, "preflush_pending");
        step();
        set_commit(8'h53, 1);
        rd_done_all = 1'b1;
        expect_at(1, F_PEND, 0, "flush_pending");
        expect_at(1, F_UNREAD, 0, "flush_unread");
        expect_at(1, F_FAIL, 0, "flush_no_fail");
        expect_at(2, F_FLAGS, 0, "flush_flags");
        expect_at(2, F_LEN, 0, "flush_len");
        step(); step();
`ifdef PP_RING_FAIL_CNT_EN
        expect_at(0, F_FCNT, 1, "flush_keeps_fail_cnt");
`endif

        // Pointers back at buffer 0: write-during-read returns the old word
        rd_addr = 9;
        write_word(9, 8'h01); step();
        write_word(9, 8'h02);
        expect_at(1, F_DATA, 8'h01, "wdr_old_word");
        expect_at(2, F_DATA, 8'h02, "wdr_new_word");
        step(); step();

        // First commit after flush lands in buffer 0
        set_commit(8'h77, 9);
        expect_at(1, F_PEND, 1, "postflush_pending");
        expect_at(2, F_FLAGS, 8'h77, "postflush_flags");
        expect_at(2, F_LEN, 9, "postflush_len");
        expect_at(2, F_DATA, 8'h02, "postflush_data");
        step();

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pp_ring_ram
`default_nettype wire
